// File: rtl/sprite_engine.sv
// Single-sprite engine: bounding-box hit test, sprite ROM addressing, and
// once-per-frame movement in manual (buttons) or bounce mode.
module sprite_engine #(
  parameter int unsigned SPR_W      = 34,
  parameter int unsigned SPR_H      = 27,
  parameter int unsigned SCALE_LOG2 = 0,
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter int unsigned START_X    = 0,
  parameter int unsigned START_Y    = 300,
  parameter int unsigned SPEED      = 3,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic              clk_pix,
  input  logic              rst,
  input  logic [9:0]        sx,
  input  logic [9:0]        sy,
  input  logic              de,
  input  logic              mode,
  input  logic              mv_right,
  input  logic              mv_left,
  input  logic              mv_up,
  input  logic              mv_down,
  input  logic              restart,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              sprite_on,
  output logic              pix_valid,
  output logic [9:0]        pos_x,
  output logic [9:0]        pos_y,
  output logic              edge_hit
);

  localparam int unsigned DW     = SPR_W << SCALE_LOG2;
  localparam int unsigned DH     = SPR_H << SCALE_LOG2;
  localparam logic [9:0]  MAX_X  = 10'(H_RES - DW);
  localparam logic [9:0]  MAX_Y  = 10'(V_RES - DH);
  localparam logic [9:0]  STEP   = 10'(SPEED);
  localparam logic [9:0]  TICK_X = 10'(H_RES - 1);
  localparam logic [9:0]  TICK_Y = 10'(V_RES - 1);

  logic              tick;
  logic              hit;
  logic [9:0]        dx;
  logic [9:0]        dy;
  logic [ADDR_W-1:0] addr_next;
  logic              dir_x;
  logic              dir_y;
  logic [10:0]       x_sum;
  logic [10:0]       y_sum;
  logic              x_over, x_under, y_over, y_under;
  logic [9:0]        x_inc, x_dec, y_inc, y_dec;
  logic [9:0]        x_man, y_man, x_bnc, y_bnc;
  logic              flip_x, flip_y;

  // Box end compared at 11 bits so pos+DW never wraps.
  always_comb begin
    tick      = (sx == TICK_X) && (sy == TICK_Y);
    hit       = de
                && (sx >= pos_x) && ({1'b0, sx} < ({1'b0, pos_x} + 11'(DW)))
                && (sy >= pos_y) && ({1'b0, sy} < ({1'b0, pos_y} + 11'(DH)));
    dx        = sx - pos_x;
    dy        = sy - pos_y;
    addr_next = '0;
    if (hit)
      addr_next = ADDR_W'(((32'(dy) >> SCALE_LOG2) * SPR_W) + (32'(dx) >> SCALE_LOG2));
  end

  always_comb begin
    x_sum   = {1'b0, pos_x} + {1'b0, STEP};
    x_over  = x_sum > {1'b0, MAX_X};
    x_under = pos_x < STEP;
    x_inc   = x_over ? MAX_X : x_sum[9:0];
    x_dec   = x_under ? '0 : pos_x - STEP;

    y_sum   = {1'b0, pos_y} + {1'b0, STEP};
    y_over  = y_sum > {1'b0, MAX_Y};
    y_under = pos_y < STEP;
    y_inc   = y_over ? MAX_Y : y_sum[9:0];
    y_dec   = y_under ? '0 : pos_y - STEP;

    x_man = pos_x;
    if (mv_right)     x_man = x_inc;
    else if (mv_left) x_man = x_dec;
    y_man = pos_y;
    if (mv_up)        y_man = y_dec;
    else if (mv_down) y_man = y_inc;

    x_bnc  = dir_x ? x_inc : x_dec;
    y_bnc  = dir_y ? y_inc : y_dec;
    flip_x = dir_x ? x_over : x_under;
    flip_y = dir_y ? y_over : y_under;
  end

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      pos_x     <= 10'(START_X);
      pos_y     <= 10'(START_Y);
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      rom_addr  <= '0;
      sprite_on <= 1'b0;
      pix_valid <= 1'b0;
      edge_hit  <= 1'b0;
    end else begin
      sprite_on <= hit;
      rom_addr  <= addr_next;
      pix_valid <= sprite_on;
      edge_hit  <= 1'b0;
      if (restart) begin
        pos_x <= 10'(START_X);
        pos_y <= 10'(START_Y);
        dir_x <= 1'b1;
        dir_y <= 1'b1;
      end else if (tick) begin
        if (mode) begin
          pos_x    <= x_bnc;
          pos_y    <= y_bnc;
          dir_x    <= dir_x ^ flip_x;
          dir_y    <= dir_y ^ flip_y;
          edge_hit <= flip_x | flip_y;
        end else begin
          pos_x <= x_man;
          pos_y <= y_man;
        end
      end
    end
  end

endmodule

// File: doc/sprite_engine.md
# sprite_engine

Parametrised sprite engine for the 640x480 VGA pipeline, replacing the single-purpose fixed-size sprite mover. It holds one sprite's position and scans the current pixel (sx, sy) against the sprite's bounding box. It generates the ROM address for the sprite ROM and moves the sprite once per frame, either from button levels (manual mode) or autonomously (bounce mode). It sits between the VGA timing generator and the per-sprite ROM. Its outputs feed the colour mux.

## Interface
- SPR_W, 34: sprite width in ROM texels
- SPR_H, 27: sprite height in ROM texels
- SCALE_LOG2, 0: display scale; each texel is drawn as a 2^SCALE_LOG2 square of pixels
- H_RES, 640: active width
- V_RES, 480: active height
- START_X, 0: position after reset or restart
- START_Y, 300: position after reset or restart
- SPEED, 3: pixels moved per frame on each axis
- ADDR_W, 10: ROM address width; must satisfy 2^ADDR_W >= SPR_W*SPR_H

Ports:
- clk_pix  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- sx  in  10  current pixel x
- sy  in  10  current pixel y
- de  in  1  display enable
- mode  in  1  0 = manual, 1 = bounce
- mv_right, mv_left, mv_up, mv_down  in  1 each  debounced button levels
- restart  in  1  synchronous return to the start position
- rom_addr  out  ADDR_W  ROM address
- sprite_on  out  1  registered hit flag, aligned with rom_addr
- pix_valid  out  1  sprite_on delayed one cycle, aligned with the synchronous ROM dataout
- pos_x  out  10  current sprite x (top-left)
- pos_y  out  10  current sprite y (top-left)
- edge_hit  out  1  one-cycle pulse when bounce mode reverses direction

## Operation
- Derived sizes: DW = SPR_W<<SCALE_LOG2 and DH = SPR_H<<SCALE_LOG2.
- Elaboration constraints: DW <= H_RES, DH <= V_RES, START_X <= H_RES-DW, START_Y <= V_RES-DH.
- Hit test: de && sx >= pos_x && sx < pos_x+DW && sy >= pos_y && sy < pos_y+DH. Every texel is covered, including the first column and last row.
- Address: rom_addr = ((sy-pos_y)>>SCALE_LOG2)*SPR_W + ((sx-pos_x)>>SCALE_LOG2). Compute at 11-bit width or wider so pos_x+DW does not wrap.
- When there is no hit, sprite_on = 0 and rom_addr = 0.
- Frame tick: sx == H_RES-1 && sy == V_RES-1. The tick does not depend on de.
- Manual mode, evaluated at each tick:
  - Horizontal: right has priority over left.
  - Vertical: up has priority over down.
  - The two axes are independent.
  - Movement saturates at the bounds:
    - right: pos_x = min(pos_x+SPEED, H_RES-DW)
    - left: pos_x = (pos_x < SPEED) ? 0 : pos_x-SPEED
    - Y axis behaves the same way against V_RES-DH.
- Bounce mode, evaluated at each tick:
  - Direction registers are dir_x (1 = right) and dir_y (1 = down).
  - Each axis moves SPEED in its current direction.
  - If the move would pass a bound, the position clamps to that bound and the axis direction flips.
  - Buttons are ignored in this mode.
- edge_hit: asserted for one cycle after any flip. Flips on both axes in the same tick produce a single pulse.
- Mode change: takes effect at the next tick. Direction registers keep their values across mode changes.
- restart: sets pos to (START_X, START_Y) and dir_x = dir_y = 1. If restart and a tick occur in the same cycle, restart wins.
- rst: immediately sets
  - pos_x, pos_y to START_X, START_Y
  - dir_x = dir_y = 1
  - rom_addr, sprite_on, pix_valid, edge_hit to 0

## Timing
- sprite_on and rom_addr are registered and appear 1 cycle after the sx/sy they describe.
- pix_valid appears 2 cycles after sx/sy, matching the 1-cycle ROM read.
- Position is updated in the cycle after the tick. The new position is visible from the first pixel of the next frame, so there is no mid-frame tearing.
- edge_hit is high in the same cycle the new position appears.
- Reset is asynchronous on assertion. Deassertion must be synchronous to clk_pix; the top-level reset synchroniser provides this.
- Reset in the middle of a line clears the outputs immediately. The hit pipeline refills within 2 cycles of release.

## Test plan
- Defaults, pos (0,300), sx=0 and sy=300 (first texel) -> next cycle sprite_on=1, rom_addr=0. sx=5, sy=302 -> next cycle sprite_on=1, rom_addr=73; the cycle after that, pix_valid=1. sx=34, sy=300 -> sprite_on=0, rom_addr=0.
- SCALE_LOG2=1, pos (100,100), sx=111, sy=103 -> rom_addr=39. sx=167 -> hit. sx=168 -> miss.
- Manual mode, pos_x=604, mv_right held for 2 ticks -> pos_x=606, then stays 606.
  - pos_x=2 with mv_left -> 0.
  - mv_right and mv_left together -> moves right.
- Bounce mode, pos (605,100), dirs (1,1), tick -> pos (606,103), dir_x=0, edge_hit pulses for exactly 1 cycle. Next tick -> pos (603,106), no pulse.
- Bounce into the corner, pos (605,452) at tick -> pos (606,453), both dirs flip, exactly one edge_hit pulse.
- restart asserted in the same cycle as a tick with mv_right held -> pos (0,300).
- rst asserted mid-line while sprite_on=1 -> all outputs 0 with no clock edge, pos returns to (0,300).
